// File: rtl/pll_loop_filter_pi.sv
`default_nettype none
// ============================================================================
// Module   : pll_loop_filter_pi
// Purpose  : PI loop filter for the digital PLL. It has a saturating leaky
//            integrator, a proportional path, a quantised output and a lock detector.
// Revision : 1.0  initial release
// ============================================================================
module pll_loop_filter_pi #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 12,
    parameter int ACC_W      = 12,
    parameter int FRAC_W     = 0,
    parameter int KI_SHL     = 1,
    parameter int KP_SHL     = 0,
    parameter int LEAK_SHIFT = 4,
    parameter int QUANT_BITS = 4,
    parameter int LOCK_THR   = 4,
    parameter int LOCK_CNT   = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CLEAR,
    input  logic                    HOLD,
    input  logic                    IN_VALID,
    input  logic signed [IN_W-1:0]  C,
    output logic                    OUT_VALID,
    output logic signed [OUT_W-1:0] D1,
    output logic signed [OUT_W-1:0] D2,
    output logic                    SAT,
    output logic                    LOCK
);

    localparam int AW    = ACC_W + IN_W + KI_SHL + 2;
    localparam int PW    = ACC_W + IN_W + KP_SHL + 2;
    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    localparam logic signed [AW-1:0] ACC_MAX = {{(AW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [PW-1:0] OUT_MAX = {{(PW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [PW-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [ACC_W-1:0] acc;
    logic signed [IN_W-1:0]  err_d;
    logic                    v_d;
    logic                    hold_d;
    logic                    sat_a;
    logic [CNT_W-1:0]        lock_cnt;

    logic signed [AW-1:0]    acc_ext;
    logic signed [AW-1:0]    ki_term;
    logic signed [AW-1:0]    leak;
    logic signed [AW-1:0]    acc_sum;
    logic signed [ACC_W-1:0] acc_clamped;
    logic                    acc_clip;

    logic signed [PW-1:0]    acc_pw;
    logic signed [PW-1:0]    int_term;
    logic signed [PW-1:0]    p_term;
    logic signed [PW-1:0]    out_sum;
    logic signed [OUT_W-1:0] d1_next;
    logic signed [OUT_W-1:0] d2_next;
    logic                    out_clip;

    logic signed [IN_W:0]    err_wide;
    logic signed [IN_W:0]    err_abs;
    logic                    err_is_min;
    logic                    in_window;
    logic [CNT_W-1:0]        cnt_next;

    assign acc_ext = {{(AW - ACC_W){acc[ACC_W-1]}}, acc};
    assign ki_term = {{(AW - IN_W){C[IN_W-1]}}, C} <<< KI_SHL;

    generate
        if (LEAK_SHIFT > 0) begin : g_leak
            assign leak = acc_ext >>> LEAK_SHIFT;
        end else begin : g_no_leak
            assign leak = '0;
        end
    endgenerate

    assign acc_sum = acc_ext + ki_term - leak;

    always_comb begin
        acc_clamped = acc_sum[ACC_W-1:0];
        acc_clip    = 1'b0;
        if (acc_sum > ACC_MAX) begin
            acc_clamped = ACC_MAX[ACC_W-1:0];
            acc_clip    = 1'b1;
        end else if (acc_sum < ACC_MIN) begin
            acc_clamped = ACC_MIN[ACC_W-1:0];
            acc_clip    = 1'b1;
        end
    end

    // Output stage reads acc after the sample's own integrator update
    assign acc_pw   = {{(PW - ACC_W){acc[ACC_W-1]}}, acc};
    assign int_term = acc_pw >>> FRAC_W;
    assign p_term   = hold_d ? '0 : ({{(PW - IN_W){err_d[IN_W-1]}}, err_d} <<< KP_SHL);
    assign out_sum  = int_term + p_term;

    always_comb begin
        d1_next  = out_sum[OUT_W-1:0];
        out_clip = 1'b0;
        if (out_sum > OUT_MAX) begin
            d1_next  = OUT_MAX[OUT_W-1:0];
            out_clip = 1'b1;
        end else if (out_sum < OUT_MIN) begin
            d1_next  = OUT_MIN[OUT_W-1:0];
            out_clip = 1'b1;
        end
    end

    generate
        if (QUANT_BITS > 0) begin : g_quant
            assign d2_next = {d1_next[OUT_W-1:QUANT_BITS], {QUANT_BITS{1'b0}}};
        end else begin : g_no_quant
            assign d2_next = d1_next;
        end
    endgenerate

    // The most negative error has no positive magnitude and never counts as in-window
    assign err_wide   = {err_d[IN_W-1], err_d};
    assign err_abs    = err_wide[IN_W] ? -err_wide : err_wide;
    assign err_is_min = (err_d == {1'b1, {(IN_W - 1){1'b0}}});
    assign in_window  = !err_is_min && (int'(err_abs) <= LOCK_THR);
    assign cnt_next   = (lock_cnt == CNT_W'(LOCK_CNT)) ? lock_cnt : lock_cnt + CNT_W'(1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc       <= '0;
            err_d     <= '0;
            v_d       <= 1'b0;
            hold_d    <= 1'b0;
            sat_a     <= 1'b0;
            lock_cnt  <= '0;
            OUT_VALID <= 1'b0;
            D1        <= '0;
            D2        <= '0;
            SAT       <= 1'b0;
            LOCK      <= 1'b0;
        end else if (CLEAR) begin
            acc       <= '0;
            v_d       <= 1'b0;
            sat_a     <= 1'b0;
            lock_cnt  <= '0;
            OUT_VALID <= 1'b0;
            LOCK      <= 1'b0;
        end else begin
            v_d       <= IN_VALID;
            OUT_VALID <= v_d;
            if (IN_VALID) begin
                err_d  <= C;
                hold_d <= HOLD;
                sat_a  <= !HOLD && acc_clip;
                if (!HOLD) begin
                    acc <= acc_clamped;
                end
            end
            if (v_d) begin
                D1  <= d1_next;
                D2  <= d2_next;
                SAT <= sat_a | out_clip;
                if (in_window) begin
                    lock_cnt <= cnt_next;
                    if (cnt_next == CNT_W'(LOCK_CNT)) begin
                        LOCK <= 1'b1;
                    end
                end else begin
                    lock_cnt <= '0;
                    LOCK     <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_loop_filter_pi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_loop_filter_pi
// Purpose  : Directed bench for pll_loop_filter_pi with an integer reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pll_loop_filter_pi;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              CLEAR;
    logic              HOLD;
    logic              IN_VALID;
    logic signed [7:0] C;
    logic              OUT_VALID;
    logic signed [11:0] D1;
    logic signed [11:0] D2;
    logic              SAT;
    logic              LOCK;

    pll_loop_filter_pi dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CLEAR    (CLEAR),
        .HOLD     (HOLD),
        .IN_VALID (IN_VALID),
        .C        (C),
        .OUT_VALID(OUT_VALID),
        .D1       (D1),
        .D2       (D2),
        .SAT      (SAT),
        .LOCK     (LOCK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int due;
        int d1;
        int d2;
        int sat;
        int lock;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   edge_n = 0;
    int   clear_edge = -1;

    // Reference state: integrator, lock counter and the values currently shown
    int m_acc = 0;
    int m_cnt = 0;
    int m_lock = 0;
    int shown_d1 = 0;
    int shown_d2 = 0;
    int shown_sat = 0;
    int shown_lock = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int clampv(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_sample(input int c, input bit h);
        exp_t e;
        int   raw;
        int   sa;
        sa = 0;
        if (!h) begin
            raw   = m_acc + c * 2 - (m_acc >>> 4);
            m_acc = clampv(raw, 12);
            sa    = (raw != m_acc) ? 1 : 0;
        end
        raw   = m_acc + (h ? 0 : c);
        e.d1  = clampv(raw, 12);
        e.d2  = (e.d1 >>> 4) * 16;
        e.sat = (sa != 0 || raw != e.d1) ? 1 : 0;
        if (c != -128 && c >= -4 && c <= 4) begin
            m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
            if (m_cnt == 16) m_lock = 1;
        end else begin
            m_cnt  = 0;
            m_lock = 0;
        end
        e.lock = m_lock;
        e.due  = edge_n + 2;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit v, input int c, input bit h, input bit clr);
        @(negedge CLK);
        IN_VALID = v;
        C        = 8'(c);
        HOLD     = h;
        CLEAR    = clr;
        if (clr) begin
            m_acc = 0;
            m_cnt = 0;
            m_lock = 0;
            exp_q.delete();
            clear_edge = edge_n + 1;
        end else if (v) begin
            model_sample(c, h);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RESET = 1'b1;
        IN_VALID = 1'b0;
        CLEAR = 1'b0;
        HOLD = 1'b0;
        C = '0;
        exp_q.delete();
        m_acc = 0; m_cnt = 0; m_lock = 0;
        shown_d1 = 0; shown_d2 = 0; shown_sat = 0; shown_lock = 0;
        #1;
        chk("rst_out_valid", int'(OUT_VALID), 0);
        chk("rst_d1", int'(D1), 0);
        chk("rst_d2", int'(D2), 0);
        chk("rst_sat", int'(SAT), 0);
        chk("rst_lock", int'(LOCK), 0);
        repeat (n) @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Per-cycle comparison against the model, 1 time unit after each rising edge
    initial begin
        exp_t e;
        int   exp_v;
        forever begin
            @(posedge CLK);
            edge_n++;
            #1;
            if (RESET) begin
                chk("reset_out_valid", int'(OUT_VALID), 0);
                chk("reset_d1", int'(D1), 0);
                chk("reset_lock", int'(LOCK), 0);
            end else begin
                if (clear_edge == edge_n) shown_lock = 0;
                exp_v = (exp_q.size() > 0 && exp_q[0].due <= edge_n) ? 1 : 0;
                chk("out_valid", int'(OUT_VALID), exp_v);
                if (exp_v != 0) begin
                    e = exp_q.pop_front();
                    shown_d1   = e.d1;
                    shown_d2   = e.d2;
                    shown_sat  = e.sat;
                    shown_lock = e.lock;
                end
                chk("d1", int'(D1), shown_d1);
                chk("d2", int'(D2), shown_d2);
                chk("sat", int'(SAT), shown_sat);
                chk("lock", int'(LOCK), shown_lock);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1;
        CLEAR = 1'b0;
        HOLD = 1'b0;
        IN_VALID = 1'b0;
        C = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // Single sample
        drive(1'b1, 8, 1'b0, 1'b0);
        chk("pin_acc_single", m_acc, 16);
        idle(3);
        chk("single_d1", int'(D1), 24);
        chk("single_d2", int'(D2), 16);
        chk("single_sat", int'(SAT), 0);
        chk("single_lock", int'(LOCK), 0);

        // Positive saturation, then leak decay
        do_reset(2);
        for (int i = 0; i < 64; i++) drive(1'b1, 127, 1'b0, 1'b0);
        chk("pin_acc_clamp", m_acc, 2047);
        idle(3);
        chk("pos_d1", int'(D1), 2047);
        chk("pos_d2", int'(D2), 2032);
        chk("pos_sat", int'(SAT), 1);
        drive(1'b1, 0, 1'b0, 1'b0);
        chk("pin_acc_decay", m_acc, 1920);
        for (int i = 0; i < 19; i++) drive(1'b1, 0, 1'b0, 1'b0);
        idle(3);
        chk("decay_sat", int'(SAT), 0);

        // Negative saturation, most negative error never locks
        do_reset(2);
        for (int i = 0; i < 64; i++) drive(1'b1, -128, 1'b0, 1'b0);
        idle(3);
        chk("neg_d1", int'(D1), -2048);
        chk("neg_d2", int'(D2), -2048);
        chk("neg_sat", int'(SAT), 1);
        chk("neg_lock", int'(LOCK), 0);

        // Hold
        do_reset(2);
        drive(1'b1, 8, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8, 1'b1, 1'b0);
        chk("pin_hold_d1", exp_q[$].d1, 16);
        drive(1'b1, 8, 1'b0, 1'b0);
        chk("pin_acc_release", m_acc, 31);
        idle(3);
        chk("release_d1", int'(D1), 39);
        chk("release_d2", int'(D2), 32);

        // Lock acquisition, loss and restart
        do_reset(2);
        for (int i = 0; i < 8; i++) drive(1'b1, 3, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 8; i++) drive(1'b1, 3, i[0], 1'b0);
        idle(2);
        chk("lock_set", int'(LOCK), 1);
        drive(1'b1, 5, 1'b0, 1'b0);
        idle(2);
        chk("lock_lost", int'(LOCK), 0);
        drive(1'b1, -4, 1'b0, 1'b0);
        chk("pin_cnt_restart", m_cnt, 1);
        idle(2);

        // Clear together with a valid sample
        do_reset(2);
        for (int i = 0; i < 5; i++) drive(1'b1, 10, 1'b0, 1'b0);
        drive(1'b1, 10, 1'b0, 1'b1);
        idle(3);
        chk("clear_d1_hold", int'(D1), 84);
        chk("clear_lock", int'(LOCK), 0);
        drive(1'b1, 8, 1'b0, 1'b0);
        idle(3);
        chk("after_clear_d1", int'(D1), 24);

        // Reset between input and output
        drive(1'b1, 8, 1'b0, 1'b0);
        do_reset(2);
        idle(2);
        drive(1'b1, 8, 1'b0, 1'b0);
        idle(3);
        chk("after_reset_d1", int'(D1), 24);
        chk("after_reset_d2", int'(D2), 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
